// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream console front end that writes the VGA text RAM, tracks the cursor and scrolls the row ring.
module text_console_writer #(
    parameter int         COLS     = 70,
    parameter int         ROWS     = 64,
    parameter int         VIS_ROWS = 30,
    parameter logic [7:0] BLANK    = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        wren,
    output logic [31:0] wraddr,
    output logic [31:0] datain,
    output logic [2:0]  memop,
    output logic [5:0]  start_line,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);
    typedef enum logic [1:0] {CLRALL, IDLE, CLRROW} state_t;
    state_t      state;
    logic [12:0] cnt;
    logic [12:0] addr;
    logic [12:0] row_base;
    logic [12:0] cur_addr;
    logic [7:0]  data;
    logic [5:0]  next_row;
    logic        accept;
    logic        printable;
    logic        at_end;
    logic        scroll;
    logic        newline;
    assign wraddr    = {19'b0, addr};
    assign datain    = {24'b0, data};
    assign memop     = 3'b000;
    assign busy      = ~char_ready;
    assign row_base  = 13'(cursor_row) * 13'(COLS);
    assign cur_addr  = row_base + 13'(cursor_col);
    assign next_row  = cursor_row + 6'd1;
    // The new row becomes the first one past the visible window, so the window follows it.
    assign scroll    = (next_row - start_line) == 6'(VIS_ROWS);
    assign accept    = char_valid && char_ready;
    assign printable = char_data >= 8'h20 && char_data <= 8'h7e;
    assign at_end    = cursor_col == 7'(COLS - 1);
    assign newline   = (printable && at_end) || char_data == 8'h0a;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLRALL;
            cnt        <= '0;
            wren       <= 1'b0;
            addr       <= '0;
            data       <= '0;
            start_line <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            char_ready <= 1'b0;
        end else begin
            wren <= 1'b0;
            case (state)
                CLRALL: begin
                    if (cnt == 13'(ROWS * COLS)) begin
                        state      <= IDLE;
                        char_ready <= 1'b1;
                        cursor_row <= '0;
                        cursor_col <= '0;
                        start_line <= '0;
                    end else begin
                        wren <= 1'b1;
                        addr <= cnt;
                        data <= BLANK;
                        cnt  <= cnt + 13'd1;
                    end
                end
                CLRROW: begin
                    if (cnt == 13'(COLS)) begin
                        state      <= IDLE;
                        char_ready <= 1'b1;
                    end else begin
                        wren <= 1'b1;
                        addr <= row_base + cnt;
                        data <= BLANK;
                        cnt  <= cnt + 13'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (printable) begin
                            wren <= 1'b1;
                            addr <= cur_addr;
                            data <= char_data;
                            if (!at_end) cursor_col <= cursor_col + 7'd1;
                        end else if (char_data == 8'h08 && cursor_col != 7'd0) begin
                            wren       <= 1'b1;
                            addr       <= cur_addr - 13'd1;
                            data       <= BLANK;
                            cursor_col <= cursor_col - 7'd1;
                        end else if (char_data == 8'h0c) begin
                            state      <= CLRALL;
                            cnt        <= '0;
                            char_ready <= 1'b0;
                        end
                        // A wrapping printable writes its byte and moves to the next row in one cycle.
                        if (newline) begin
                            cursor_row <= next_row;
                            cursor_col <= '0;
                            if (scroll) start_line <= start_line + 6'd1;
                            state      <= CLRROW;
                            cnt        <= '0;
                            char_ready <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: scoreboard bench; a cursor/ring model queues expected writes, a monitor pops them.
module tb_text_console_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready, wren, busy;
    logic [31:0] wraddr, datain;
    logic [2:0]  memop;
    logic [5:0]  start_line, cursor_row;
    logic [6:0]  cursor_col;
    int checks = 0, errors = 0, cyc = 0, last_wr = 0;
    int m_row = 0, m_col = 0, m_sl = 0;
    typedef struct {int addr; int data;} wr_t;
    wr_t exp_q[$];

    text_console_writer dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .wren(wren), .wraddr(wraddr), .datain(datain),
        .memop(memop), .start_line(start_line), .cursor_row(cursor_row),
        .cursor_col(cursor_col), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            chk("busy", int'(busy), int'(!char_ready));
            if (wren) begin
                last_wr = cyc;
                if (exp_q.size() == 0) chk("unexpected write addr", int'(wraddr), -1);
                else begin
                    e = exp_q.pop_front();
                    chk("wr addr", int'(wraddr), e.addr);
                    chk("wr data", int'(datain), e.data);
                    chk("memop", int'(memop), 0);
                end
            end
        end
    end

    function automatic void push_wr(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic model_newline();
        m_row = (m_row + 1) % 64;
        m_col = 0;
        if ((m_row - m_sl + 64) % 64 == 30) m_sl = (m_sl + 1) % 64;
        for (int k = 0; k < 70; k++) push_wr(m_row * 70 + k, 32);
    endtask

    task automatic model_clrall();
        for (int k = 0; k < 64 * 70; k++) push_wr(k, 32);
        m_row = 0;
        m_col = 0;
        m_sl = 0;
    endtask

    task automatic model(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7e) begin
            push_wr(m_row * 70 + m_col, int'(c));
            if (m_col < 69) m_col++;
            else model_newline();
        end else if (c == 8'h0a) model_newline();
        else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row * 70 + m_col, 32);
            end
        end else if (c == 8'h0c) model_clrall();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!char_ready && n < 6000) begin
            step();
            n++;
        end
        if (!char_ready) chk({name, " ready timeout"}, int'(char_ready), 1);
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready("send");
        char_valid = 1'b1;
        char_data = c;
        model(c);
        step();
        char_valid = 1'b0;
        char_data = 8'($urandom);
    endtask

    task automatic settle(input string name);
        wait_ready(name);
        chk({name, " pending writes"}, exp_q.size(), 0);
        chk({name, " row"}, int'(cursor_row), m_row);
        chk({name, " col"}, int'(cursor_col), m_col);
        chk({name, " start_line"}, int'(start_line), m_sl);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        char_valid = 1'b0;
        exp_q.delete();
        step();
        chk("rst wren", int'(wren), 0);
        chk("rst wraddr", int'(wraddr), 0);
        chk("rst datain", int'(datain), 0);
        chk("rst start_line", int'(start_line), 0);
        chk("rst row", int'(cursor_row), 0);
        chk("rst col", int'(cursor_col), 0);
        chk("rst ready", int'(char_ready), 0);
        model_clrall();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        int r;
        do_reset();
        wait_ready("clrall");
        chk("ready lag after last clear write", cyc - last_wr, 1);
        settle("clrall");
        send(8'h41);
        chk("A col", int'(cursor_col), 1);
        settle("A");
        send(8'h7f);
        settle("0x7F ignored");
        chk("0x7F col", int'(cursor_col), 1);
        send(8'h0c);
        settle("ff");
        repeat (70) send(8'h78);
        chk("clrrow ready low", int'(char_ready), 0);
        settle("wrap");
        chk("wrap row", int'(cursor_row), 1);
        chk("wrap col", int'(cursor_col), 0);
        send(8'h0c);
        settle("ff2");
        repeat (29) begin
            send(8'h0a);
            settle("nl");
        end
        chk("row 29", int'(cursor_row), 29);
        send(8'h0a);
        settle("scroll");
        chk("scroll start_line", int'(start_line), 1);
        chk("scroll row", int'(cursor_row), 30);
        repeat (33) begin
            send(8'h0a);
            settle("nl2");
        end
        repeat (5) send(8'h6b);
        settle("pre ring");
        chk("pre ring row", int'(cursor_row), 63);
        chk("pre ring col", int'(cursor_col), 5);
        chk("pre ring start_line", int'(start_line), 34);
        send(8'h0a);
        settle("ring");
        chk("ring row", int'(cursor_row), 0);
        chk("ring start_line", int'(start_line), 35);
        send(8'h0c);
        settle("ff3");
        send(8'h0a);
        send(8'h0a);
        repeat (5) send(8'h62);
        settle("pre bs");
        send(8'h08);
        settle("bs");
        chk("bs col", int'(cursor_col), 4);
        repeat (4) send(8'h08);
        settle("bs to 0");
        send(8'h08);
        settle("bs at 0");
        chk("bs at 0 col", int'(cursor_col), 0);
        chk("bs at 0 row", int'(cursor_row), 2);
        send(8'h0a);
        repeat (10) step();
        do_reset();
        settle("mid reset restart");
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) c = 8'($urandom_range(32, 126));
            else if (r < 80) c = 8'h0a;
            else if (r < 88) c = 8'h08;
            else if (r < 89) c = 8'h0c;
            else c = 8'($urandom_range(0, 255));
            send(c);
            if ($urandom_range(0, 3) == 0) step();
            if (i % 25 == 24) settle("random");
        end
        settle("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
